// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter: the measurement states and
// the number of synchronizer stages in front of the edge detector.
package period_meter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level into clk and flags its rising and falling
// edges with one extra register stage.
module edge_sync
    import period_meter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIMED = PW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [PW-1:0]          prime_q, prime_d;
    logic                   primed;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
        edge_d  = sync_q[SYNC_STAGES-1];
        prime_d = prime_q;
        if (prime_q != PRIMED) prime_d = prime_q + 1'b1;
    end

    // Edges are only reported once every stage holds a real sample, so a level
    // already high at reset release is not mistaken for a rise.
    assign primed = (prime_q == PRIMED);
    assign rise   = primed && sync_q[SYNC_STAGES-1] && !edge_q;
    assign fall   = primed && !sync_q[SYNC_STAGES-1] && edge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            edge_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            sync_q  <= sync_d;
            edge_q  <= edge_d;
            prime_q <= prime_d;
        end
    end

endmodule

// File: rtl/period_meter.sv
// Measures clk cycles between rising edges of a slow asynchronous square wave and
// holds each result for a valid/ready consumer. PERIOD_METER_HIGH_TIME_EN adds high_time.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sig_in,
    output logic         meas_valid,
    input  logic         meas_ready,
    output logic [W-1:0] period,
    output logic         overflow,
    output logic         dropped
`ifdef PERIOD_METER_HIGH_TIME_EN
    ,
    output logic [W-1:0] high_time
`endif
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] ONE     = W'(1);

    logic         sync_rise, sync_fall;
    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_pend_q, ovf_pend_d;
    logic [W-1:0] period_q, period_d;
    logic         overflow_q, overflow_d;
    logic         valid_q, valid_d;
    logic         dropped_q, dropped_d;
    logic         capture, hs, load_res;

    edge_sync u_edge_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (sync_rise),
        .fall   (sync_fall)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        period_d   = period_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        dropped_d  = dropped_q;
        capture    = 1'b0;
        hs         = valid_q && meas_ready;

        case (state_q)
            IDLE: begin
                if (sync_rise) begin
                    state_d    = COUNT;
                    cnt_d      = ONE;
                    ovf_pend_d = 1'b0;
                end
            end
            COUNT: begin
                if (sync_rise) begin
                    capture    = 1'b1;
                    cnt_d      = ONE;
                    ovf_pend_d = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d      = cnt_q + ONE;
                    ovf_pend_d = ovf_pend_q | (cnt_q == CNT_MAX - ONE);
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture only lands if the holding register is free or being emptied now.
        load_res = capture && (!valid_q || hs);
        if (load_res) begin
            period_d   = cnt_q;
            overflow_d = ovf_pend_q;
            valid_d    = 1'b1;
        end else begin
            if (capture) dropped_d = 1'b1;
            if (hs)      valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            period_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            period_q   <= period_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            dropped_q  <= dropped_d;
        end
    end

    assign meas_valid = valid_q;
    assign period     = period_q;
    assign overflow   = overflow_q;
    assign dropped    = dropped_q;

`ifdef PERIOD_METER_HIGH_TIME_EN
    logic         hi_run_q, hi_run_d;
    logic [W-1:0] hi_cnt_q, hi_cnt_d;
    logic [W-1:0] hi_lat_q, hi_lat_d;
    logic [W-1:0] high_time_q, high_time_d;

    // High time runs from the detected rise and is frozen at the detected fall.
    always_comb begin
        hi_run_d    = hi_run_q;
        hi_cnt_d    = hi_cnt_q;
        hi_lat_d    = hi_lat_q;
        high_time_d = high_time_q;
        if (sync_rise) begin
            hi_run_d = 1'b1;
            hi_cnt_d = ONE;
        end else if (sync_fall && hi_run_q) begin
            hi_run_d = 1'b0;
            hi_lat_d = hi_cnt_q;
        end else if (hi_run_q && hi_cnt_q != CNT_MAX) begin
            hi_cnt_d = hi_cnt_q + ONE;
        end
        if (load_res) high_time_d = hi_lat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_run_q    <= 1'b0;
            hi_cnt_q    <= '0;
            hi_lat_q    <= '0;
            high_time_q <= '0;
        end else begin
            hi_run_q    <= hi_run_d;
            hi_cnt_q    <= hi_cnt_d;
            hi_lat_q    <= hi_lat_d;
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`else
    logic unused_fall;
    assign unused_fall = sync_fall;
`endif

endmodule
